// File: rtl/fft_trig_pkg.sv
// Shared constants for the FFT bin trigger: default frame geometry, FSM state
// encoding and the bin-window clamp bounds with their helper functions.
package fft_trig_pkg;

  localparam int FFT_POINTS = 64;
  localparam int COMP_W     = 16;

  // FSM state encoding
  localparam logic [1:0] ARMED   = 2'd0;
  localparam logic [1:0] CONFIRM = 2'd1;
  localparam logic [1:0] HOLDOFF = 2'd2;

  // Only the lower half of the spectrum may qualify for the window
  localparam int WIN_MIN = 0;
  localparam int WIN_MAX = 31;

  // Lower window bound: centre - offset, clamped at WIN_MIN
  function automatic logic [4:0] win_lo_of(input logic [3:0] freq, input logic [1:0] off);
    logic [4:0] centre;
    centre = {freq, 1'b0};
    return (centre >= {3'b000, off}) ? (centre - {3'b000, off}) : 5'(WIN_MIN);
  endfunction

  // Upper window bound: centre + offset, clamped at WIN_MAX
  function automatic logic [4:0] win_hi_of(input logic [3:0] freq, input logic [1:0] off);
    logic [5:0] total;
    total = {1'b0, freq, 1'b0} + {4'b0000, off};
    return (total > 6'(WIN_MAX)) ? 5'(WIN_MAX) : total[4:0];
  endfunction

endpackage

// File: rtl/fft_bin_trigger_mag.sv
// fft_mag_l1: two-stage L1 magnitude path. Stage 1 registers |re|, |im| and
// the beat sideband; stage 2 registers the running window peak together with
// the frame-end / malformed-frame flags for the frame the beat belongs to.
module fft_mag_l1 #(
  parameter int COMP_W = 16,
  parameter int IDX_W  = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  beat_valid,
  input  logic [2*COMP_W-1:0]   beat_data,
  input  logic [IDX_W-1:0]      beat_idx,
  input  logic                  beat_last,
  input  logic [IDX_W-1:0]      win_lo,
  input  logic [IDX_W-1:0]      win_hi,
  output logic                  frame_end,
  output logic                  frame_bad,
  output logic [COMP_W:0]       win_peak
);
  import fft_trig_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};

  // Unsigned magnitude of a two's complement value; the most negative value
  // maps to 2^(COMP_W-1), which still fits in COMP_W unsigned bits.
  function automatic logic [COMP_W-1:0] abs_u(input logic [COMP_W-1:0] v);
    return v[COMP_W-1] ? (~v + 1'b1) : v;
  endfunction

  logic                 s1_valid_reg;
  logic [IDX_W-1:0]     s1_idx_reg;
  logic                 s1_last_reg;
  logic [COMP_W:0]      mag_sum;
  logic                 in_win;
  logic [COMP_W:0]      peak_reg;
  logic [COMP_W:0]      peak_next;
  logic                 end_reg;
  logic                 bad_reg;

  // Component 0 is real, component 1 is imaginary
  for (genvar gi = 0; gi < 2; gi++) begin : g_abs
    logic [COMP_W-1:0] abs_reg;
    // Stage 1: register the magnitude of one component
    always_ff @(posedge clk) begin
      if (reset) abs_reg <= '0;
      else       abs_reg <= abs_u(beat_data[gi*COMP_W +: COMP_W]);
    end
  end

  // Stage 1: beat sideband follows the magnitudes
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
      s1_idx_reg   <= '0;
      s1_last_reg  <= 1'b0;
    end else begin
      s1_valid_reg <= beat_valid;
      s1_idx_reg   <= beat_idx;
      s1_last_reg  <= beat_last;
    end
  end

  assign mag_sum = {1'b0, g_abs[0].abs_reg} + {1'b0, g_abs[1].abs_reg};
  assign in_win  = (s1_idx_reg >= win_lo) && (s1_idx_reg <= win_hi) &&
                   (s1_idx_reg <= IDX_W'(WIN_MAX));

  // Running window max, restarted by the first beat of every frame
  always_comb begin
    peak_next = peak_reg;
    if (s1_idx_reg == '0)
      peak_next = in_win ? mag_sum : '0;
    else if (in_win && (mag_sum > peak_reg))
      peak_next = mag_sum;
  end

  // Stage 2: register window peak and the frame-boundary verdict
  always_ff @(posedge clk) begin
    if (reset) begin
      peak_reg <= '0;
      end_reg  <= 1'b0;
      bad_reg  <= 1'b0;
    end else begin
      end_reg <= s1_valid_reg & s1_last_reg & (s1_idx_reg == LAST_IDX);
      bad_reg <= s1_valid_reg & (s1_last_reg ^ (s1_idx_reg == LAST_IDX));
      if (s1_valid_reg) peak_reg <= peak_next;
    end
  end

  assign frame_end = end_reg;
  assign frame_bad = bad_reg;
  assign win_peak  = peak_reg;

endmodule

// File: rtl/fft_bin_trigger.sv
// fft_bin_trigger: per-frame L1 window peak detector with a consecutive-hit
// trigger FSM. Build option FFT_TRIG_HOLDOFF_EN adds a HOLDOFF state that
// ignores HOLDOFF_FRAMES evaluated frames after each fire.
module fft_bin_trigger #(
  parameter int FFT_POINTS     = fft_trig_pkg::FFT_POINTS,
  parameter int COMP_W         = fft_trig_pkg::COMP_W,
  parameter int THRESH_SHIFT   = 12,
  parameter int FRAMES_REQ     = 2,
  parameter int HOLDOFF_FRAMES = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2*COMP_W-1:0] s_tdata,
  input  logic                s_tvalid,
  input  logic                s_tlast,
  output logic                s_tready,
  input  logic [3:0]          frequency,
  input  logic [1:0]          offset,
  input  logic [3:0]          threshold,
  output logic                trigger,
  output logic                fft_data_ready,
  output logic [COMP_W:0]     peak_mag,
  output logic                frame_err
);
  import fft_trig_pkg::*;

  localparam int IDX_W = $clog2(FFT_POINTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT_POINTS - 1);

  logic               beat_acc;
  logic [IDX_W-1:0]   bin_idx_reg;
  logic [IDX_W-1:0]   win_lo_reg;
  logic [IDX_W-1:0]   win_hi_reg;
  logic [3:0]         thr_lat_reg;
  logic [3:0]         thr_s2_reg;
  logic               frame_end;
  logic               frame_bad;
  logic [COMP_W:0]    win_peak;
  logic [COMP_W:0]    thr_full;
  logic               hit;
  logic               fire;
  logic [1:0]         state_reg;
  logic [1:0]         state_next;
  logic [3:0]         cnt_reg;
  logic [3:0]         cnt_next;
  logic               trigger_reg;
  logic               ready_reg;
  logic               err_reg;
  logic [COMP_W:0]    peak_reg;

  assign s_tready = ~reset;
  assign beat_acc = s_tvalid & s_tready;

  // Bin counter: wraps after the last bin and resynchronises on any tlast
  always_ff @(posedge clk) begin
    if (reset)
      bin_idx_reg <= '0;
    else if (beat_acc)
      bin_idx_reg <= (s_tlast || bin_idx_reg == LAST_IDX) ? '0 : bin_idx_reg + 1'b1;
  end

  // Controls are captured at bin 0 so mid-frame changes wait for the next frame
  always_ff @(posedge clk) begin
    if (reset) begin
      win_lo_reg  <= '0;
      win_hi_reg  <= '0;
      thr_lat_reg <= '0;
    end else if (beat_acc && bin_idx_reg == '0) begin
      win_lo_reg  <= IDX_W'(win_lo_of(frequency, offset));
      win_hi_reg  <= IDX_W'(win_hi_of(frequency, offset));
      thr_lat_reg <= threshold;
    end
  end

  // Threshold delayed one stage so the compare still sees the finishing
  // frame's value after the next frame has latched its own at bin 0
  always_ff @(posedge clk) begin
    if (reset) thr_s2_reg <= '0;
    else       thr_s2_reg <= thr_lat_reg;
  end

  fft_mag_l1 #(
    .COMP_W (COMP_W),
    .IDX_W  (IDX_W)
  ) u_mag (
    .clk        (clk),
    .reset      (reset),
    .beat_valid (beat_acc),
    .beat_data  (s_tdata),
    .beat_idx   (bin_idx_reg),
    .beat_last  (s_tlast),
    .win_lo     (win_lo_reg),
    .win_hi     (win_hi_reg),
    .frame_end  (frame_end),
    .frame_bad  (frame_bad),
    .win_peak   (win_peak)
  );

  assign thr_full = (COMP_W+1)'(thr_s2_reg) << THRESH_SHIFT;
  assign hit      = (thr_s2_reg != 4'd0) && (win_peak >= thr_full);

`ifdef FFT_TRIG_HOLDOFF_EN
  localparam int HOLD_W = $clog2(HOLDOFF_FRAMES + 1);
  logic [HOLD_W-1:0] hold_cnt_reg;
  logic [HOLD_W-1:0] hold_cnt_next;
`endif

  // Trigger FSM, advanced only by well-formed frames
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    fire       = 1'b0;
`ifdef FFT_TRIG_HOLDOFF_EN
    hold_cnt_next = hold_cnt_reg;
`endif
    if (frame_end) begin
      case (state_reg)
        ARMED: begin
          if (hit) begin
            if (FRAMES_REQ == 1) begin
              fire = 1'b1;
            end else begin
              state_next = CONFIRM;
              cnt_next   = 4'd1;
            end
          end
        end
        CONFIRM: begin
          if (hit) begin
            if (cnt_reg + 4'd1 == 4'(FRAMES_REQ)) fire = 1'b1;
            else                                  cnt_next = cnt_reg + 4'd1;
          end else begin
            state_next = ARMED;
            cnt_next   = 4'd0;
          end
        end
`ifdef FFT_TRIG_HOLDOFF_EN
        HOLDOFF: begin
          if (hold_cnt_reg == HOLD_W'(HOLDOFF_FRAMES - 1)) begin
            state_next    = ARMED;
            hold_cnt_next = '0;
          end else begin
            hold_cnt_next = hold_cnt_reg + 1'b1;
          end
        end
`endif
        default: begin
          state_next = ARMED;
          cnt_next   = 4'd0;
        end
      endcase
      if (fire) begin
`ifdef FFT_TRIG_HOLDOFF_EN
        state_next    = HOLDOFF;
        hold_cnt_next = '0;
`else
        state_next = ARMED;
`endif
        cnt_next = 4'd0;
      end
    end
  end

  // Stage 3: FSM update and output pulses/peak
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ARMED;
      cnt_reg     <= 4'd0;
      trigger_reg <= 1'b0;
      ready_reg   <= 1'b0;
      err_reg     <= 1'b0;
      peak_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      trigger_reg <= fire;
      ready_reg   <= frame_end;
      err_reg     <= frame_bad;
      if (frame_end) peak_reg <= win_peak;
    end
  end

`ifdef FFT_TRIG_HOLDOFF_EN
  // Holdoff frame counter
  always_ff @(posedge clk) begin
    if (reset) hold_cnt_reg <= '0;
    else       hold_cnt_reg <= hold_cnt_next;
  end
`endif

  assign trigger        = trigger_reg;
  assign fft_data_ready = ready_reg;
  assign frame_err      = err_reg;
  assign peak_mag       = peak_reg;

endmodule

// File: tb/tb_fft_bin_trigger.sv
// Directed bench for fft_bin_trigger: two instances (FRAMES_REQ=1 and 2) share
// one stimulus stream; expected per-frame outputs are queued when a frame's
// final beat is driven and checked when the output pulses appear.
module tb_fft_bin_trigger;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tlast;
  logic [3:0]  frequency;
  logic [1:0]  offset;
  logic [3:0]  threshold;

  logic        a_tready, a_trig, a_ready, a_err;
  logic [16:0] a_peak;
  logic        b_tready, b_trig, b_ready, b_err;
  logic [16:0] b_peak;

  always #5 clk = ~clk;

  fft_bin_trigger #(.FRAMES_REQ(1), .HOLDOFF_FRAMES(16)) dut_a (
    .clk(clk), .reset(reset), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tlast(s_tlast), .s_tready(a_tready), .frequency(frequency),
    .offset(offset), .threshold(threshold), .trigger(a_trig),
    .fft_data_ready(a_ready), .peak_mag(a_peak), .frame_err(a_err)
  );

  fft_bin_trigger #(.FRAMES_REQ(2), .HOLDOFF_FRAMES(16)) dut_b (
    .clk(clk), .reset(reset), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tlast(s_tlast), .s_tready(b_tready), .frequency(frequency),
    .offset(offset), .threshold(threshold), .trigger(b_trig),
    .fft_data_ready(b_ready), .peak_mag(b_peak), .frame_err(b_err)
  );

  typedef struct {
    int          cyc;
    logic        rdy;
    logic        err;
    logic        ta;
    logic        tb;
    logic [16:0] peak;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  logic signed [15:0] fre [64];
  logic signed [15:0] fim [64];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic rdy, input logic err, input logic ta,
                              input logic tb, input logic [16:0] peak);
    exp_t e;
    e.cyc = 0; e.rdy = rdy; e.err = err; e.ta = ta; e.tb = tb; e.peak = peak;
    return e;
  endfunction

  // Output monitor: every pulse must match the oldest queued expectation
  always @(posedge clk) begin
    #1;
    if (a_ready | a_err | a_trig | b_ready | b_err | b_trig) begin
      $display("out cyc=%0d rdy=%0d/%0d err=%0d/%0d trig=%0d/%0d peak=%0d/%0d",
               cyc, a_ready, b_ready, a_err, b_err, a_trig, b_trig, a_peak, b_peak);
      chk("expected_pulse", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("out_cycle", cyc, mon_e.cyc);
        chk("a_ready", 32'(a_ready), 32'(mon_e.rdy));
        chk("b_ready", 32'(b_ready), 32'(mon_e.rdy));
        chk("a_err",   32'(a_err),   32'(mon_e.err));
        chk("b_err",   32'(b_err),   32'(mon_e.err));
        chk("a_trig",  32'(a_trig),  32'(mon_e.ta));
        chk("b_trig",  32'(b_trig),  32'(mon_e.tb));
        chk("a_peak",  32'(a_peak),  32'(mon_e.peak));
        chk("b_peak",  32'(b_peak),  32'(mon_e.peak));
      end
    end
  end

  task automatic clear_frame();
    for (int i = 0; i < 64; i++) begin
      fre[i] = '0;
      fim[i] = '0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_a_trig"},  32'(a_trig),  32'd0);
    chk({tag, "_b_trig"},  32'(b_trig),  32'd0);
    chk({tag, "_a_ready"}, 32'(a_ready), 32'd0);
    chk({tag, "_b_ready"}, 32'(b_ready), 32'd0);
    chk({tag, "_a_err"},   32'(a_err),   32'd0);
    chk({tag, "_a_peak"},  32'(a_peak),  32'd0);
    chk({tag, "_b_peak"},  32'(b_peak),  32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    chk("reset_a_tready", 32'(a_tready), 32'd0);
    chk("reset_b_tready", 32'(b_tready), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("run_a_tready", 32'(a_tready), 32'd1);
  endtask

  // Drives nbeats beats back to back; the final beat carries end_last as tlast.
  // mid_thr >= 0 changes threshold after bin 0 has been accepted.
  task automatic send_frame(input int nbeats, input logic end_last,
                            input logic [3:0] fq, input logic [1:0] off,
                            input logic [3:0] th, input int mid_thr,
                            input exp_t e, input logic push);
    frequency = fq;
    offset    = off;
    threshold = th;
    for (int i = 0; i < nbeats; i++) begin
      s_tdata  = {fim[i], fre[i]};
      s_tvalid = 1'b1;
      s_tlast  = (i == nbeats - 1) ? end_last : 1'b0;
      if (i == 1 && mid_thr >= 0) threshold = 4'(mid_thr);
      if (i == nbeats - 1 && push) begin
        e.cyc = cyc + 3;
        sb.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  initial begin
    logic ea, eb;
    reset = 1'b1; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
    frequency = '0; offset = '0; threshold = '0;
    clear_frame();

    // Single-bin hit then threshold-2 miss; a mid-frame threshold change to 0
    // must not affect the frame already in progress
    do_reset();
    clear_frame();
    fre[10] = 16'sd3000;
    fim[10] = -16'sd2000;
    send_frame(64, 1'b1, 4'd5, 2'd0, 4'd1, 0, mk(1, 0, 1, 0, 17'd5000), 1'b1);
    send_frame(64, 1'b1, 4'd5, 2'd0, 4'd2, -1, mk(1, 0, 0, 0, 17'd5000), 1'b1);
    idle(6);

    // Hit, miss, then 20 hits back to back
    do_reset();
    for (int f = 1; f <= 22; f++) begin
`ifdef FFT_TRIG_HOLDOFF_EN
      ea = (f == 1) || (f == 18);
      eb = (f == 4) || (f == 22);
`else
      ea = (f != 2);
      eb = (f >= 4) && (f % 2 == 0);
`endif
      send_frame(64, 1'b1, 4'd5, 2'd0, (f == 2) ? 4'd2 : 4'd1, -1,
                 mk(1, 0, ea, eb, 17'd5000), 1'b1);
    end
    idle(6);

    // Malformed frames (early tlast, missing tlast), then full-scale bin 0,
    // then a window clamped at bin 31 with energy just outside it
    do_reset();
    clear_frame();
    fre[2] = 16'sd1000;
    send_frame(41, 1'b1, 4'd1, 2'd0, 4'd1, -1, mk(0, 1, 0, 0, 17'd0), 1'b1);
    clear_frame();
    fre[10] = 16'sd3000;
    fim[10] = -16'sd2000;
    send_frame(64, 1'b0, 4'd5, 2'd0, 4'd1, -1, mk(0, 1, 0, 0, 17'd0), 1'b1);
    clear_frame();
    fre[0] = 16'sh8000;
    fim[0] = 16'sh8000;
    send_frame(64, 1'b1, 4'd0, 2'd3, 4'd15, -1, mk(1, 0, 1, 0, 17'd65536), 1'b1);
    clear_frame();
    fre[26] = 16'sd30000;
    fre[27] = 16'sd100;
    fim[27] = -16'sd200;
    fre[32] = 16'sd20000;
    send_frame(64, 1'b1, 4'd15, 2'd3, 4'd1, -1, mk(1, 0, 0, 0, 17'd300), 1'b1);
    idle(6);

    // Reset two cycles after the frame-end beat: nothing may emerge
    do_reset();
    clear_frame();
    fre[10] = 16'sd3000;
    fim[10] = -16'sd2000;
    send_frame(64, 1'b1, 4'd5, 2'd0, 4'd1, -1, mk(0, 0, 0, 0, 17'd0), 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_quiet("midreset");
    chk("midreset_a_tready", 32'(a_tready), 32'd0);
    reset = 1'b0;
    idle(8);
    check_quiet("postreset");

    idle(4);
    chk("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_bin_trigger.md
# fft_bin_trigger

Streaming trigger detector directly downstream of the trigger FFT: accepts the FFT master AXI-Stream output (one 64-point frame per burst) and computes an L1 magnitude per bin. It takes the peak over a programmable bin window and asserts a one-cycle `trigger` once that peak meets a programmable threshold for a required number of consecutive frames. It also produces the per-frame `fft_data_ready` pulse and peak magnitude used by downstream capture logic.

## Interface
- `FFT_POINTS`, 64: frame length in beats; bin counter width is log2(FFT_POINTS).
- `COMP_W`, 16: width of each signed real/imag component in `s_tdata`.
- `THRESH_SHIFT`, 12: left shift applied to the 4-bit `threshold` to form the magnitude threshold.
- `FRAMES_REQ`, 2: consecutive hit frames required to fire; legal range 1–15.
- `HOLDOFF_FRAMES`, 16: frames ignored after a fire (only with `FFT_TRIG_HOLDOFF_EN`).
- `clk` in 1: single clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `s_tdata` in 2*COMP_W: {imag[31:16], real[15:0]}, both two's complement.
- `s_tvalid` in 1: beat valid.
- `s_tlast` in 1: last beat of frame.
- `s_tready` out 1: 0 while `reset` is high, otherwise constant 1.
- `frequency` in 4: centre bin = {frequency,1'b0} (0..30).
- `offset` in 2: window half-width; window = centre±offset, clamped to 0..31.
- `threshold` in 4: 0 = detection disabled; otherwise thr = threshold << THRESH_SHIFT.
- `trigger` out 1: one-cycle fire pulse.
- `fft_data_ready` out 1: one-cycle pulse per valid evaluated frame.
- `peak_mag` out COMP_W+1: window peak of the last valid frame; holds until the next valid frame.
- `frame_err` out 1: one-cycle pulse when a frame is malformed.

## Operation
- Beat accepted when `s_tvalid & s_tready`. The bin counter increments per accepted beat and resets to 0 after index 63 or on any `s_tlast`.
- At the accepted beat with index 0, latch `frequency`, `offset` and `threshold`. Mid-frame changes take effect at the next frame.
- Magnitude: |re|+|im|, unsigned, COMP_W+1 bits. |−32768| = 32768, computed without overflow.
- Running max: for beats whose index lies in the window (bins 32..63 never qualify), keep the max magnitude. Clear it at frame start.
- Frame end is a beat with index 63 and `s_tlast`=1. On frame end, `hit` = (latched threshold≠0) & (peak ≥ thr), and the frame is evaluated.
- Malformed frame: `s_tlast` at index≠63, or index 63 without `s_tlast`. Either case pulses `frame_err`, discards the frame (no `fft_data_ready`, FSM unchanged) and restarts the counter at 0.
- FSM, advancing only on evaluated frames:
  - ARMED: on hit with FRAMES_REQ=1, fire; on hit otherwise, go to CONFIRM with cnt=1; on miss, stay.
  - CONFIRM: on hit, cnt++; when cnt reaches FRAMES_REQ, fire. On miss, go to ARMED with cnt=0.
  - HOLDOFF: count evaluated frames and ignore hits; after HOLDOFF_FRAMES frames, go to ARMED.
  - Fire: pulse `trigger` and leave to HOLDOFF (macro defined) or ARMED (macro undefined), with cnt=0.

## Timing
- Pipeline: stage 1 registers abs(re), abs(im), index and last; stage 2 registers the sum and window max; stage 3 registers the compare and FSM update.
- `fft_data_ready`, `trigger`, `frame_err` and the `peak_mag` update all occur 3 cycles after the frame-end beat is accepted. `trigger` and `fft_data_ready` assert in the same cycle.
- Back-to-back frames with no idle cycles are supported; frame-N evaluation overlaps frame-N+1 stage 1.
- Reset values: `trigger`=0, `fft_data_ready`=0, `frame_err`=0, `peak_mag`=0, `s_tready`=0, FSM=ARMED, cnt=0, bin counter=0.
- Reset mid-frame: the partial frame is discarded and all in-flight pipeline stages are cleared, so no pulse emerges after reset.

## Configuration
- `FFT_TRIG_HOLDOFF_EN` defined: HOLDOFF state and the HOLDOFF_FRAMES counter are present.
- Undefined: no HOLDOFF state; after a fire, the FSM returns to ARMED and refires after another FRAMES_REQ consecutive hits.

## Structure
- Package `fft_trig_pkg`: FFT_POINTS, COMP_W, state encoding (ARMED, CONFIRM, HOLDOFF) and the window clamp bounds.
- Sub-module `fft_mag_l1`: a registered abs/sum unit (stages 1–2 magnitude path), instantiated once.

## Test plan
- Frame with bin 10 = (3000, −2000), all others 0; frequency=5, offset=0, threshold=1, FRAMES_REQ=1 → peak_mag=5000 and `trigger` plus `fft_data_ready` 3 cycles after tlast.
- Same stimulus with threshold=2 (thr=8192) → `fft_data_ready` only, peak_mag=5000, no `trigger`.
- FRAMES_REQ=2 with hit, miss, hit, hit frames → exactly one `trigger`, on the 4th frame. With the macro on and HOLDOFF_FRAMES=16, 16 further hit frames give no `trigger` and the 18th hit frame fires.
- `s_tlast` at index 40 → `frame_err` pulse, no `fft_data_ready`; the next well-formed frame evaluates normally.
- Bin 0 = (−32768, −32768), frequency=0, offset=3, threshold=15 → peak_mag=65536; 65536 ≥ 61440, so it fires.
- `reset` asserted 2 cycles after the frame-end beat → no `trigger` or `fft_data_ready` emerges; all outputs 0.
